// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// FSM state encoding and the rotating-priority winner search.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // First requester at or after ptr (mod NUM_REQ). Scanning from the far
    // end means the closest candidate is written last and wins. With no
    // request the result is ptr; callers qualify it with |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) idx = cand;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_decoder_2to4.sv
// Plain 2-to-4 one-hot decoder; turns the registered grant index into the
// grant vector.
module decoder_2to4 (
    input  logic A0,
    input  logic A1,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3
);

    assign D0 = ~A1 & ~A0;
    assign D1 = ~A1 &  A0;
    assign D2 =  A1 & ~A0;
    assign D3 =  A1 &  A0;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded tenure. A winner is
// picked from IDLE, holds the resource for up to HOLD_MAX cycles, and every
// tenure ends with one RELEASE cycle before the next arbitration.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_i,
    output logic [3:0]   gnt_o,
    output logic [1:0]   gnt_idx_o,
    output logic         gnt_valid_o,
    output logic         timeout_o,
    output logic         busy_o
);

    localparam int              HCW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_MAX - 1);

    state_e               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [HCW-1:0]       hold_cnt_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic                 gnt_valid_q;
    logic                 timeout_q;
    logic                 busy_q;

    logic [IDX_W-1:0]     win_idx;
    logic                 any_req;
    logic                 own_req;
    logic                 hold_done;
    logic [HCW-1:0]       hold_cnt_d;
    logic [IDX_W-1:0]     ptr_d;
    logic [NUM_REQ-1:0]   dec;

    // Winner search and tenure bookkeeping are purely combinational; only
    // the FSM below holds state.
    assign win_idx    = rr_pick(req_i, ptr_q);
    assign any_req    = |req_i;
    assign own_req    = req_i[gnt_idx_q];
    assign hold_done  = (hold_cnt_q == HOLD_LAST);
    assign hold_cnt_d = hold_cnt_q + HCW'(1);
    assign ptr_d      = gnt_idx_q + IDX_W'(1);

    // Arbitration FSM with registered outputs; the pointer moves past the
    // winner whenever a tenure ends, whatever the reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (any_req) begin
                        state_q     <= ST_GRANT;
                        gnt_idx_q   <= win_idx;
                        hold_cnt_q  <= '0;
                        gnt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!own_req || hold_done) begin
                        // Still requesting at the limit means the tenure
                        // was cut short, which is what timeout reports.
                        state_q     <= ST_RELEASE;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= own_req;
                        ptr_q       <= ptr_d;
                    end else begin
                        hold_cnt_q  <= hold_cnt_d;
                    end
                end
                ST_RELEASE: begin
                    state_q   <= ST_IDLE;
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    decoder_2to4 u_dec (
        .A0 (gnt_idx_q[0]),
        .A1 (gnt_idx_q[1]),
        .D0 (dec[0]),
        .D1 (dec[1]),
        .D2 (dec[2]),
        .D3 (dec[3])
    );

    // gnt_valid_q is cleared by the async reset, so the grant drops at once.
    assign gnt_o       = dec & {NUM_REQ{gnt_valid_q}};
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4. Stimulus pushes the hand-derived output
// expected after each edge; a monitor pops and compares one cycle later.
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_i = 4'b0;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       gnt_valid_o;
    logic       timeout_o;
    logic       busy_o;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    rr_arbiter4 #(.HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.gnt  = gnt_o;
        a.idx  = gnt_idx_o;
        a.vld  = gnt_valid_o;
        a.to   = timeout_o;
        a.busy = busy_o;
        return a;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got gnt/idx/vld/to/busy=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Drive req for one edge and queue what the outputs must be after it.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] idx, input logic to, input logic bsy);
        exp_t e;
        @(negedge clk);
        req_i  = r;
        e.gnt  = g;
        e.idx  = idx;
        e.vld  = |g;
        e.to   = to;
        e.busy = bsy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_i = 4'b0;
        @(posedge clk);
        #2;
        chk("reset_state", actual(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle invariants plus scoreboard compare.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #2;
            chk("onehot_inv", 9'({($countones(gnt_o) <= 1), (gnt_valid_o == (|gnt_o))}), 9'b11);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, actual(), e);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [1:0] k;
        do_reset();

        // All four requesting: full-length tenures rotate 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            k = 2'(t % 4);
            for (int c = 0; c < 8; c++) cyc("rr_hold", 4'hF, 4'b0001 << k, k, 1'b0, 1'b1);
            cyc("rr_timeout", 4'hF, 4'b0, k, 1'b1, 1'b1);
            cyc("rr_idle",    4'hF, 4'b0, k, 1'b0, 1'b0);
        end
        cyc("rr_stop", 4'h0, 4'b0, 2'd0, 1'b0, 1'b0);

        do_reset();

        // 0101 from ptr=0: requester 0 for 3 cycles, voluntary drop, then 2.
        cyc("a_g0",   4'b0101, 4'b0001, 2'd0, 1'b0, 1'b1);
        cyc("a_g0",   4'b0101, 4'b0001, 2'd0, 1'b0, 1'b1);
        cyc("a_g0",   4'b0101, 4'b0001, 2'd0, 1'b0, 1'b1);
        cyc("a_rel",  4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1);
        cyc("a_idle", 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc("a_g2",   4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
        cyc("a_rel2", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1);
        cyc("a_idl2", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // ptr=3 now: 1001 picks 3, then pointer wraps to 0.
        cyc("c_g3",   4'b1001, 4'b1000, 2'd3, 1'b0, 1'b1);
        cyc("c_rel",  4'b0001, 4'b0000, 2'd3, 1'b0, 1'b1);
        cyc("c_idle", 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0);
        cyc("c_g0",   4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
        cyc("c_rel0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        cyc("c_idl0", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // ptr=1: single-cycle pulse on req[2].
        cyc("d_g2",   4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
        cyc("d_rel",  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1);
        cyc("d_idle", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        cyc("d_stay", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // ptr=3: grant requester 1, then reset mid-tenure between edges.
        cyc("e_g1",   4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1);
        cyc("e_g1",   4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", actual(), 9'b0);
        req_i = 4'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("e_restart", 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b1);
        cyc("e_rel",     4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1);
        cyc("e_idle",    4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drained", 9'(exp_q.size()), 9'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive grant cycles per tenure; legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines; req[i] high means requester i wants the shared resource.
REQ-005 gnt  output  4  one-hot grant; at most one bit high in any cycle.
REQ-006 gnt_idx  output  2  binary index of current/last granted requester.
REQ-007 gnt_valid  output  1  high exactly when some gnt bit is high.
REQ-008 timeout  output  1  one-cycle pulse when a tenure is ended by HOLD_MAX.
REQ-009 busy  output  1  high when FSM is not IDLE.

Function
REQ-010 FSM states: IDLE, GRANT, RELEASE; encoding is implementation choice.
REQ-011 IDLE, req==0: stay IDLE; outputs gnt=0, gnt_valid=0.
REQ-012 IDLE, req!=0: winner = first i with req[i]=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); next state GRANT; gnt_idx<=winner; hold_cnt<=0.
REQ-013 Latency: req sampled at edge N yields gnt[winner]=1 after edge N (1 cycle).
REQ-014 gnt is produced by decoding gnt_idx through the 2-to-4 decoder sub-module, gated by gnt_valid; no other path drives gnt.
REQ-015 GRANT: hold_cnt increments each cycle; grant held while req[gnt_idx]=1 and hold_cnt < HOLD_MAX-1.
REQ-016 GRANT exit on req[gnt_idx]=0 (voluntary) or hold_cnt==HOLD_MAX-1 with req still high (forced): next state RELEASE, gnt deasserted on that edge.
REQ-017 Tenure length: grant visible for at most HOLD_MAX cycles.
REQ-018 Forced exit pulses timeout for exactly the first RELEASE cycle; voluntary exit never pulses timeout.
REQ-019 On any GRANT exit, ptr <= gnt_idx+1 mod 4 (3 wraps to 0).
REQ-020 RELEASE: exactly one cycle, gnt=0, then IDLE unconditionally; guarantees one dead cycle between tenures.
REQ-021 Changes to non-granted req bits during GRANT/RELEASE have no effect until IDLE arbitration.
REQ-022 gnt_idx retains last winner in RELEASE and IDLE.
REQ-023 busy=1 in GRANT and RELEASE, 0 in IDLE.

Reset
REQ-024 rst_n low forces immediately (no clock): state=IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt=0, gnt_valid=0, timeout=0, busy=0.
REQ-025 Reset asserted mid-tenure drops gnt asynchronously; after release, arbitration restarts from ptr=0.
REQ-026 First arbitration occurs at the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package holds FSM state constants and NUM_REQ=4; HOLD_MAX stays a module parameter.
REQ-028 hold_cnt width = clog2(HOLD_MAX).
REQ-029 One sub-module: decoder_2to4 (inputs A0,A1; outputs D0..D3), instantiated once for gnt generation.
REQ-030 Winner selection is combinational from req and ptr; all outputs except gnt are registered.

Verification
REQ-031 req=4'b0101 held, ptr=0 after reset -> gnt=0001; drop req[0] after 3 cycles -> 1 RELEASE cycle, then gnt=0100.
REQ-032 req=4'b1111 held, HOLD_MAX=8 -> grants cycle 0,1,2,3,0, each exactly 8 cycles, timeout pulses after each, one dead cycle between.
REQ-033 Wrap: ptr=3 (after tenure of 2), req=4'b1001 -> gnt=1000, then ptr=0 -> gnt=0001.
REQ-034 rst_n low during gnt=0010 -> gnt=0000 same cycle without clock edge; after release, req=4'b0110 -> gnt=0010 (ptr=0).
REQ-035 One-cycle req[2] pulse in IDLE with others low -> gnt=0100 for 1 cycle, RELEASE, IDLE, timeout=0.
REQ-036 Every cycle assertion: popcount(gnt)<=1 and gnt_valid==|gnt.
